// File: rtl/packetizer_stream_if.sv
// Stream bundle between a beat producer, the packetizer and the fabric port.
// The slave modport is the packetizer's view; master is the producer/consumer side.
interface packetizer_stream_if #(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_OUT        = 36,
   parameter int FLITS            = 4
) ();
   localparam int WIDTH_IN = WIDTH_OUT - FLITS*(3+VC_ADDRESS_WIDTH) - ADDRESS_WIDTH;
   localparam int NFW      = $clog2(FLITS);

   logic [WIDTH_IN-1:0]      i_data_in;
   logic                     i_valid_in;
   logic [NFW-1:0]           i_nflit_in;
   logic [ADDRESS_WIDTH-1:0] i_dest_in;
   logic                     i_last_in;
   logic                     i_ready_out;
   logic [WIDTH_OUT-1:0]     o_packet_out;
   logic                     o_valid_out;
   logic                     o_ready_in;

   modport slave (
      input  i_data_in, i_valid_in, i_nflit_in, i_dest_in, i_last_in, o_ready_in,
      output i_ready_out, o_packet_out, o_valid_out
   );

   modport master (
      output i_data_in, i_valid_in, i_nflit_in, i_dest_in, i_last_in, o_ready_in,
      input  i_ready_out, o_packet_out, o_valid_out
   );
endinterface

// File: rtl/packetizer_stream.sv
// Packetizer: formats input beats into multi-flit fabric words, splitting long
// messages into packets of at most MAX_PKT_WORDS words, with a 2-entry output FIFO.
//
// state | meaning
// IDLE  | next accepted beat starts a new message (latches dest)
// BODY  | mid-message; dest held, word counter tracks packet length
module packetizer_stream #(
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_OUT        = 36,
   parameter int FLITS            = 4,
   parameter int MAX_PKT_WORDS    = 4,
   parameter int VC_MODE          = 0,
   parameter int ASSIGNED_VC      = 0
) (
   input logic               clk,
   input logic               rst_n,
   packetizer_stream_if.slave bus
);
   localparam int VCW      = VC_ADDRESS_WIDTH;
   localparam int FW       = WIDTH_OUT / FLITS;
   localparam int WIDTH_IN = WIDTH_OUT - FLITS*(3+VCW) - ADDRESS_WIDTH;
   localparam int P0       = FW - 3 - VCW - ADDRESS_WIDTH;   // payload bits in flit 0
   localparam int P        = FW - 3 - VCW;                   // payload bits in other flits
   localparam int WCW      = $clog2(MAX_PKT_WORDS + 1);

   typedef enum logic {IDLE, BODY} state_t;

   state_t                   state_q, state_d;
   logic [WCW-1:0]           wcnt_q, wcnt_d;
   logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
   logic [VCW-1:0]           vc_q, vc_d;
   logic                     sop, eop;
   logic                     ready, accept, pop;
   logic [WIDTH_OUT-1:0]     word_d;

   logic [WIDTH_OUT-1:0]     mem_q [2];
   logic                     wr_q, rd_q;
   logic [1:0]               occ_q;

   // Ready is forced low while reset is held so nothing is accepted then.
   assign ready           = rst_n && (occ_q != 2'd2);
   assign accept          = bus.i_valid_in && ready;
   assign pop             = (occ_q != 2'd0) && bus.o_ready_in;
   assign bus.i_ready_out = ready;
   assign bus.o_valid_out = (occ_q != 2'd0);
   assign bus.o_packet_out = mem_q[rd_q];

   // Packet state register: FSM state, word counter, latched dest and current VC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         dest_q  <= '0;
         vc_q    <= VCW'(ASSIGNED_VC);
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         dest_q  <= dest_d;
         vc_q    <= vc_d;
      end
   end

   // Next state: a last beat always returns to IDLE, any other beat lands in BODY.
   always_comb begin
      state_d = state_q;
      if (accept) state_d = bus.i_last_in ? IDLE : BODY;
   end

   // Per-beat framing: sop/eop, counter update, dest selection and VC advance.
   always_comb begin
      sop    = 1'b0;
      wcnt_d = wcnt_q;
      dest_d = dest_q;
      if (accept) begin
         if (state_q == IDLE) begin
            sop    = 1'b1;
            wcnt_d = WCW'(1);
            dest_d = bus.i_dest_in;
         end else if (wcnt_q == WCW'(MAX_PKT_WORDS)) begin
            // Packet is full: start a continuation packet to the same dest.
            sop    = 1'b1;
            wcnt_d = WCW'(1);
         end else begin
            wcnt_d = wcnt_q + WCW'(1);
         end
      end
      eop  = bus.i_last_in || (wcnt_d == WCW'(MAX_PKT_WORDS));
      vc_d = vc_q;
      if (VC_MODE == 1 && accept && eop) vc_d = vc_q + VCW'(1);
   end

   // Word assembly: flit 0 at the MSBs, payload taken MSB-first, unused flits zero.
   always_comb begin
      logic [FW-1:0] flit;
      word_d = '0;
      flit   = '0;
      flit[FW-1]                 = 1'b1;
      flit[FW-2]                 = sop;
      flit[FW-3]                 = eop && (bus.i_nflit_in == '0);
      flit[FW-4 -: VCW]          = vc_q;
      flit[P0+ADDRESS_WIDTH-1:0] = {dest_d, bus.i_data_in[WIDTH_IN-1 -: P0]};
      word_d[WIDTH_OUT-1 -: FW]  = flit;
      for (int k = 1; k < FLITS; k++) begin
         flit = '0;
         if (k <= int'(bus.i_nflit_in)) begin
            flit[FW-1]        = 1'b1;
            flit[FW-3]        = eop && (k == int'(bus.i_nflit_in));
            flit[FW-4 -: VCW] = vc_q;
            flit[P-1:0]       = bus.i_data_in[WIDTH_IN-1-P0-(k-1)*P -: P];
         end
         word_d[WIDTH_OUT-1-k*FW -: FW] = flit;
      end
   end

   // Two-entry output FIFO; the head entry drives the port directly so it holds under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (accept) begin
            mem_q[wr_q] <= word_d;
            wr_q        <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         if (accept && !pop)      occ_q <= occ_q + 2'd1;
         else if (!accept && pop) occ_q <= occ_q - 2'd1;
      end
   end
endmodule

// File: tb/tb_packetizer_stream.sv
// Directed bench for the packetizer with VC_MODE=1 and default geometry
// (4 flits of 9 bits, 16-bit payload, 4-bit dest, 1-bit VC).
module tb_packetizer_stream;
   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [35:0] exp_q [$];
   logic        m_body;
   logic [2:0]  m_wcnt;
   logic [3:0]  m_dest;
   logic        m_vc;

   packetizer_stream_if #(.ADDRESS_WIDTH(4), .VC_ADDRESS_WIDTH(1), .WIDTH_OUT(36), .FLITS(4)) bus ();

   packetizer_stream #(
      .ADDRESS_WIDTH(4), .VC_ADDRESS_WIDTH(1), .WIDTH_OUT(36), .FLITS(4),
      .MAX_PKT_WORDS(4), .VC_MODE(1), .ASSIGNED_VC(0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference word layout for this geometry, written field by field.
   function automatic logic [35:0] exp_word(input logic [15:0] d, input logic [1:0] nf,
                                            input logic [3:0] dest, input logic sop,
                                            input logic eop, input logic vc);
      logic [8:0] f0, f1, f2, f3;
      f0 = {1'b1, sop, eop && (nf == 2'd0), vc, dest, d[15]};
      f1 = (nf >= 2'd1) ? {1'b1, 1'b0, eop && (nf == 2'd1), vc, d[14:10]} : 9'h0;
      f2 = (nf >= 2'd2) ? {1'b1, 1'b0, eop && (nf == 2'd2), vc, d[9:5]}   : 9'h0;
      f3 = (nf == 2'd3) ? {1'b1, 1'b0, eop,                 vc, d[4:0]}   : 9'h0;
      return {f0, f1, f2, f3};
   endfunction

   task automatic model_reset();
      m_body = 1'b0;
      m_wcnt = 3'd0;
      m_dest = 4'd0;
      m_vc   = 1'b0;
   endtask

   task automatic model_accept(input logic [15:0] d, input logic [1:0] nf,
                               input logic [3:0] dest, input logic last);
      logic sop, eop;
      if (!m_body) begin
         m_dest = dest; sop = 1'b1; m_wcnt = 3'd1;
      end else if (m_wcnt == 3'd4) begin
         sop = 1'b1; m_wcnt = 3'd1;
      end else begin
         sop = 1'b0; m_wcnt = m_wcnt + 3'd1;
      end
      eop    = last || (m_wcnt == 3'd4);
      m_body = !last;
      exp_q.push_back(exp_word(d, nf, m_dest, sop, eop, m_vc));
      if (eop) m_vc = ~m_vc;
   endtask

   // Offers one beat from a falling edge and returns 1 time unit after the accepting edge.
   task automatic send(input logic [15:0] d, input logic [1:0] nf,
                       input logic [3:0] dest, input logic last);
      int n;
      @(negedge clk);
      bus.i_data_in  = d;
      bus.i_nflit_in = nf;
      bus.i_dest_in  = dest;
      bus.i_last_in  = last;
      bus.i_valid_in = 1'b1;
      n = 0;
      while (!bus.i_ready_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk("accept_timeout", 36'(bus.i_ready_out), 36'd1);
      end else begin
         model_accept(d, nf, dest, last);
         @(posedge clk);
      end
      #1;
      bus.i_valid_in = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("drain", 36'(exp_q.size()), 36'd0);
   endtask

   // Output monitor: pops the scoreboard on each handshake, checks hold under stall.
   initial begin
      logic        prev_stall;
      logic [35:0] prev_word;
      logic [35:0] e;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 36'(bus.o_valid_out), 36'd1);
               chk("hold_word", bus.o_packet_out, prev_word);
            end
            if (bus.o_valid_out && bus.o_ready_in) begin
               n_tests++;
               assert (exp_q.size() > 0) else begin
                  n_fail++;
                  $error("FAIL spurious_word: observed %h expected none", bus.o_packet_out);
               end
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("word", bus.o_packet_out, e);
               end
            end
            prev_stall = bus.o_valid_out && !bus.o_ready_in;
            prev_word  = bus.o_packet_out;
         end
      end
   end

   initial begin
      logic [15:0] d;
      model_reset();
      rst_n          = 1'b0;
      bus.i_data_in  = '0;
      bus.i_valid_in = 1'b0;
      bus.i_nflit_in = '0;
      bus.i_dest_in  = '0;
      bus.i_last_in  = 1'b0;
      bus.o_ready_in = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_valid", 36'(bus.o_valid_out), 36'd0);
      chk("rst_ready", 36'(bus.i_ready_out), 36'd0);
      chk("rst_packet", bus.o_packet_out, 36'd0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", 36'(bus.i_ready_out), 36'd1);

      // Single full beat to dest 5: one-cycle latency and fixed field positions.
      send(16'hA5C3, 2'd3, 4'd5, 1'b1);
      chk("latency_valid", 36'(bus.o_valid_out), 36'd1);
      chk("single_valid0", 36'(bus.o_packet_out[35]), 36'd1);
      chk("single_sop0", 36'(bus.o_packet_out[34]), 36'd1);
      chk("single_dest", 36'(bus.o_packet_out[31:28]), 36'd5);
      chk("single_eop3", 36'(bus.o_packet_out[6]), 36'd1);
      chk("single_valid3", 36'(bus.o_packet_out[8]), 36'd1);
      wait_drain();

      // Six-beat message: split after 4 words, dest changes mid-message ignored.
      for (int i = 0; i < 6; i++) begin
         d = 16'($urandom);
         send(d, (i == 5) ? 2'd2 : 2'd3, (i == 0) ? 4'd9 : 4'($urandom), (i == 5));
      end
      wait_drain();

      // Three single-beat messages: VC alternates per packet.
      for (int i = 0; i < 3; i++) begin
         logic vc_exp;
         vc_exp = m_vc;
         d = 16'($urandom);
         send(d, 2'd3, 4'(i + 1), 1'b1);
         chk("vc_rr", 36'(bus.o_packet_out[32]), 36'(vc_exp));
      end
      wait_drain();

      // Two valid flits: upper flits fully zero, eop on flit 1.
      send(16'hFFFF, 2'd1, 4'd3, 1'b1);
      chk("nflit1_zero", 36'(bus.o_packet_out[17:0]), 36'd0);
      chk("nflit1_eop1", 36'(bus.o_packet_out[24]), 36'd1);
      wait_drain();

      // Downstream stall for 3 cycles: ready drops after two accepts.
      @(posedge clk);
      #1 bus.o_ready_in = 1'b0;
      send(16'h1234, 2'd3, 4'd7, 1'b0);
      send(16'h5678, 2'd3, 4'd7, 1'b0);
      @(negedge clk);
      chk("stall_ready", 36'(bus.i_ready_out), 36'd0);
      @(posedge clk);
      @(negedge clk);
      chk("stall_ready2", 36'(bus.i_ready_out), 36'd0);
      @(posedge clk);
      #1 bus.o_ready_in = 1'b1;
      send(16'h9ABC, 2'd3, 4'd7, 1'b1);
      wait_drain();

      // Reset after beat 2 of 3: in-flight word dropped, next beat starts a packet.
      send(16'h1111, 2'd3, 4'd4, 1'b0);
      send(16'h2222, 2'd3, 4'd4, 1'b0);
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      chk("midrst_valid", 36'(bus.o_valid_out), 36'd0);
      chk("midrst_packet", bus.o_packet_out, 36'd0);
      chk("midrst_ready", 36'(bus.i_ready_out), 36'd0);
      rst_n = 1'b1;
      #1;
      chk("midrst_ready_up", 36'(bus.i_ready_out), 36'd1);
      send(16'h3333, 2'd3, 4'd6, 1'b1);
      chk("post_rst_sop", 36'(bus.o_packet_out[34]), 36'd1);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/packetizer_stream.md
PACKETIZER_STREAM -- requirements
Module: packetizer_stream

Interface -- parameters (name, default, meaning)
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 4, destination router address width.
REQ-002 The block SHALL have parameter VC_ADDRESS_WIDTH, default 1, VC field width (VCW).
REQ-003 The block SHALL have parameter WIDTH_OUT, default 36, fabric port word width.
REQ-004 The block SHALL have parameter FLITS, default 4, flits per output word; FW = WIDTH_OUT/FLITS; FLITS >= 2.
REQ-005 The block SHALL have parameter MAX_PKT_WORDS, default 4, maximum output words per packet, >= 1.
REQ-006 The block SHALL have parameter VC_MODE, default 0: 0 = fixed ASSIGNED_VC, 1 = round-robin VC per packet.
REQ-007 The block SHALL have parameter ASSIGNED_VC, default 0, VC used in mode 0 and first VC after reset in mode 1.
REQ-008 The block SHALL derive localparam WIDTH_IN = WIDTH_OUT - FLITS*(3+VCW) - ADDRESS_WIDTH.

Interface -- ports (name, direction, width, meaning)
REQ-009 clk, input, 1: single clock; all state is clocked on its rising edge.
REQ-010 rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-011 i_data_in, input, WIDTH_IN: beat payload, MSB-first.
REQ-012 i_valid_in, input, 1: beat offered.
REQ-013 i_nflit_in, input, clog2(FLITS): valid flits in beat minus one.
REQ-014 i_dest_in, input, ADDRESS_WIDTH: message destination, sampled on the first beat of a message only.
REQ-015 i_last_in, input, 1: beat is last of the message.
REQ-016 i_ready_out, output, 1: beat accepted when i_valid_in && i_ready_out.
REQ-017 o_packet_out, output, WIDTH_OUT: formatted word.
REQ-018 o_valid_out, output, 1: word offered.
REQ-019 o_ready_in, input, 1: downstream accepts the word when o_valid_out && o_ready_in.

Function
REQ-020 Each flit k (k=0 at MSBs) SHALL be {valid, sop, eop, vc, payload}; flit 0 also carries dest immediately after vc.
REQ-021 Payload SHALL fill flits in order from i_data_in MSB; flits with k > i_nflit_in SHALL have valid=0 and all other bits 0.
REQ-022 Flit 0 sop SHALL be 1 on the first word of each packet; the eop of flit i_nflit_in SHALL be 1 on the last word of each packet; other sop/eop bits SHALL be 0.
REQ-023 The state machine SHALL have states IDLE (next beat starts a message) and BODY (mid-message), with word counter wcnt.
REQ-024 IDLE, beat accepted: latch dest, sop=1, wcnt=1; next state IDLE if i_last_in, else BODY.
REQ-025 BODY, beat accepted: sop=1 if wcnt==MAX_PKT_WORDS (split; wcnt=1), else sop=0 and wcnt+1.
REQ-026 A word SHALL be eop when i_last_in=1 or wcnt (after update) == MAX_PKT_WORDS; a message that is split SHALL reuse the latched dest.
REQ-027 The VC SHALL be fixed at packet start; in VC_MODE 1 it SHALL increment modulo 2^VCW after each eop word and wrap.
REQ-028 Output SHALL be a 2-entry FIFO; i_ready_out = (occupancy < 2); throughput SHALL be one word per cycle.
REQ-029 Latency SHALL be exactly 1 cycle from acceptance to o_valid_out when the FIFO is empty.
REQ-030 Simultaneous push and pop at occupancy 2 SHALL NOT occur (ready is low); at occupancy 1 they SHALL leave occupancy 1.
REQ-031 o_packet_out and o_valid_out SHALL hold stable while o_valid_out && !o_ready_in.
REQ-032 i_dest_in changes during BODY SHALL be ignored.

Reset
REQ-033 While rst_n=0: o_valid_out=0, i_ready_out=0, o_packet_out=0, state=IDLE, wcnt=0, vc=ASSIGNED_VC, FIFO empty.
REQ-034 Reset mid-message SHALL discard the partial packet; the first beat after reset SHALL carry sop=1.
REQ-035 i_ready_out SHALL go to 1 in the first cycle after rst_n deasserts.

Verification
REQ-036 Single beat, nflit=3, last=1, dest=5 -> one word next cycle, flit0 sop=1 dest=5, flit3 eop=1, all valid=1.
REQ-037 6-beat message, MAX_PKT_WORDS=4 -> words 1 and 5 sop=1, words 4 and 6 eop=1, dest constant across all.
REQ-038 VC_MODE=1, VCW=1, three 1-beat messages -> vc 0,1,0.
REQ-039 nflit=1 -> flits 2,3 entirely zero; eop on flit 1.
REQ-040 o_ready_in held 0 for 3 cycles during a stream -> i_ready_out falls after 2 accepts; no loss or reorder; output stable.
REQ-041 rst_n pulsed low after beat 2 of 3 -> outputs clear immediately; next beat emits sop=1.
